clk_divider_multi: RTL
======================

// Module: clk_divider_multi
// PURPOSE
//  Multi-channel programmable clock divider. Successor to the single fixed-factor divider.
//  Each channel has a runtime divisor, a runtime high-time and an enable.
//  Each channel outputs a divided clock-enable waveform and a one-cycle wrap tick.
//  Sits between the board clock and slow logic: display scan, debouncers, FSM stepping.
// PARAMETERS
//  NUM_CH   4              number of independent channels
//  CNT_W    32             counter / divisor width in bits
//  DEF_DIV  32'd100000000  divisor loaded at reset into every channel (1 Hz at 100 MHz)
// PORTS
//  clk          in   1             system clock; all logic on posedge
//  rst_n        in   1             asynchronous reset, active-low
//  ch_en        in   NUM_CH        per-channel enable
//  cfg_we       in   1             config write strobe, single cycle
//  cfg_ch       in   $clog2(NUM_CH) target channel for cfg_we
//  cfg_div      in   CNT_W         new period in clk cycles
//  cfg_high     in   CNT_W         new high-time in clk cycles
//  out_clk      out  NUM_CH        divided waveform per channel, registered
//  tick         out  NUM_CH        1-cycle pulse on the last count of each period, registered
//  cfg_pending  out  NUM_CH        shadow config waiting for period boundary
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - cnt=0, out_clk=0, tick=0, cfg_pending=0.
//   - active div = shadow div = DEF_DIV.
//   - active high = shadow high = DEF_DIV/2.
//  Period
//   - P = (div==0) ? 1 : div. cnt counts 0..P-1, then wraps to 0.
//  Outputs (evaluated with cnt before the increment, registered)
//   - out_clk <= (cnt < high).
//   - tick <= (cnt == P-1).
//   - Both outputs lag cnt by one cycle, matching the original divider.
//  Saturation cases
//   - high >= P: out_clk constant 1.
//   - high == 0: out_clk constant 0.
//   - P == 1: tick constant 1 while enabled.
//  Enable
//   - ch_en[i]=0: cnt held at 0; out_clk and tick driven 0 next cycle.
//   - ch_en[i] 0->1: counting starts at cnt=0, so the first period is full length.
//  Config writes
//   - cfg_we with cfg_ch < NUM_CH writes the shadow and sets cfg_pending[ch].
//   - cfg_ch >= NUM_CH: write ignored, no state changes.
//   - Shadow is copied to active on the wrap cycle (cnt==P-1, enabled); cfg_pending clears
//     the same edge. No runt or glitch periods are produced.
//   - Channel disabled: shadow is copied to active on the edge after the write; cfg_pending
//     is high for exactly one cycle.
//   - Write on the wrap cycle: the new cfg values bypass the shadow and become active
//     directly; cfg_pending stays 0.
//   - Back-to-back writes to the same channel before a wrap: last write wins.
//  Arithmetic
//   - All compares are unsigned, CNT_W wide. cnt+1 never overflows because cnt < P <= 2^CNT_W-1.
//  Reset mid-period
//   - Immediate return to reset state; the pending config is lost.
//   - Channels are independent. Simultaneous wraps on several channels are legal.
// STRUCTURE
//  - Package clk_div_pkg: CNT_W default, DEF_DIV default, and typedef ch_cfg_t {div, high}.
//  - Sub-module clk_div_channel: one counter, shadow/active cfg, out_clk and tick regs.
//    Instantiated NUM_CH times in a generate loop.
//  - Top level: cfg_ch decode to per-channel write strobes, and port concatenation only.
// TESTING
//  - Reset, DEF_DIV=10: out_clk=1 for 5 cycles then 0 for 5, repeating.
//    tick pulses every 10 cycles, 1 cycle after cnt=9.
//  - Write ch1 div=4 high=1 mid-period while enabled: cfg_pending[1]=1 until the wrap.
//    From the next period: out_clk pattern 1000, tick every 4 cycles.
//  - div=0 and div=1 on ch2: tick held at 1. high=0 -> out_clk=0; high=5 -> out_clk=1.
//  - Drop ch_en[0] mid-period, then raise it after 3 cycles: out_clk and tick go 0.
//    After re-enable, the first full period starts from cnt=0.
//  - cfg_we on the exact wrap cycle of ch3 (div 6 -> 3): the next period is 3 cycles with no
//    pending. Also write cfg_ch=NUM_CH: no channel changes.
//  - Assert rst_n=0 mid-period with a config pending: all outputs are 0 asynchronously.
//    After release, DEF_DIV timing resumes and the pending config is discarded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults, configuration record and period helper for the
// multi-channel programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam logic [CNT_W_DEF-1:0] DEF_DIV_DEF = 32'd100000000;

  localparam logic [CNT_W_DEF-1:0] CNT_ZERO = {CNT_W_DEF{1'b0}};
  localparam logic [CNT_W_DEF-1:0] CNT_ONE  = {{(CNT_W_DEF-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [CNT_W_DEF-1:0] div;
    logic [CNT_W_DEF-1:0] high;
  } ch_cfg_t;

  // Final count of a period; a divisor of zero behaves as a period of one.
  function automatic logic [CNT_W_DEF-1:0] last_count(input logic [CNT_W_DEF-1:0] div);
    logic [CNT_W_DEF-1:0] res;
    if (div == CNT_ZERO) begin
      res = CNT_ZERO;
    end else begin
      res = div - CNT_ONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, shadow/active configuration and the
// registered divided-clock and wrap-tick outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter logic [CNT_W_DEF-1:0] DEF_DIV = DEF_DIV_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en_i,
  input  logic    cfg_we_i,
  input  ch_cfg_t cfg_i,
  output logic    out_clk_o,
  output logic    tick_o,
  output logic    cfg_pending_o
);

  localparam ch_cfg_t RST_CFG = '{div: DEF_DIV, high: (DEF_DIV >> 1)};

  logic [CNT_W_DEF-1:0] cnt_q, cnt_d;
  ch_cfg_t              active_q, active_d;
  ch_cfg_t              shadow_q, shadow_d;
  logic                 pend_q, pend_d;
  logic                 out_clk_q, out_clk_d;
  logic                 tick_q, tick_d;
  logic                 last_s;
  logic                 wrap_s;

  // Counter advance, output decode and shadow-to-active hand-over.
  always_comb begin
    last_s    = (cnt_q == last_count(active_q.div));
    wrap_s    = en_i && last_s;
    cnt_d     = CNT_ZERO;
    out_clk_d = 1'b0;
    tick_d    = 1'b0;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;

    if (en_i && !last_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end

    if (en_i) begin
      out_clk_d = (cnt_q < active_q.high);
      tick_d    = last_s;
    end else begin
      out_clk_d = 1'b0;
      tick_d    = 1'b0;
    end

    // A write landing on the wrap edge takes effect at once, never via the shadow.
    if (cfg_we_i && wrap_s) begin
      active_d = cfg_i;
      shadow_d = cfg_i;
      pend_d   = 1'b0;
    end else if (cfg_we_i) begin
      shadow_d = cfg_i;
      pend_d   = 1'b1;
    end else if (pend_q && (wrap_s || !en_i)) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else begin
      pend_d   = pend_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= CNT_ZERO;
      active_q  <= RST_CFG;
      shadow_q  <= RST_CFG;
      pend_q    <= 1'b0;
      out_clk_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      out_clk_q <= out_clk_d;
      tick_q    <= tick_d;
    end
  end

  assign out_clk_o     = out_clk_q;
  assign tick_o        = tick_q;
  assign cfg_pending_o = pend_q;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: decodes config writes to the
// addressed channel and gathers the per-channel outputs.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned      NUM_CH  = 4,
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = DEF_DIV_DEF,
  localparam int unsigned     CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] out_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [31:0]       ch_sel_s;
  logic [NUM_CH-1:0] we_s;
  ch_cfg_t           cfg_s;

  assign ch_sel_s = 32'(cfg_ch);
  assign cfg_s    = '{div: cfg_div, high: cfg_high};

  // Out-of-range channel numbers match no instance, so such writes are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign we_s[g] = cfg_we && (ch_sel_s == 32'(g));

    clk_div_channel #(
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (ch_en[g]),
      .cfg_we_i     (we_s[g]),
      .cfg_i        (cfg_s),
      .out_clk_o    (out_clk[g]),
      .tick_o       (tick[g]),
      .cfg_pending_o(cfg_pending[g])
    );
  end

endmodule
